// File: rtl/fifo_read_streamer_if.sv
// Bundles the async-FIFO read port and the downstream valid/ready stream.
// master: the streamer's view (pops the FIFO, drives the stream).
// slave: the environment's view (FIFO read port plus the stream sink).
interface fifo_read_streamer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  empty;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  m_valid;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  m_ready;

   modport master (
      input  empty,
      output r_en,
      input  fifo_data,
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      output empty,
      input  r_en,
      output fifo_data,
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/fifo_read_streamer.sv
// Pops an async FIFO's read port, absorbs its 1-cycle read latency and streams words with a packet-last marker.
// Latency: empty falls in T -> r_en in T -> m_valid in T+2; sustains one word per cycle.
// Backpressure: 3-entry skid buffer; pops stop once buffered + outstanding reaches 3, no comb path m_ready -> r_en.
//
// Ports:
//   rclk, rrst      read-domain clock, synchronous active-high reset
//   bus (master)    empty/r_en/fifo_data from the FIFO, m_valid/m_data/m_last/m_ready to the sink
//   level           words currently held in the skid buffer (0..3)
//   beats           total accepted beats, wraps modulo 2^CNT_WIDTH
module fifo_read_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 rclk,
   input  logic                 rrst,
   fifo_read_streamer_if.master bus,
   output logic [1:0]           level,
   output logic [CNT_WIDTH-1:0] beats
);

   localparam int BCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BCW-1:0] BEAT_LAST = BCW'(PKT_LEN - 1);

   logic [DATA_WIDTH-1:0] buf_mem [3];
   logic [1:0]            wi;
   logic [1:0]            ri;
   logic                  inflight;
   logic [BCW-1:0]        beat_cnt;
   logic [2:0]            occupancy;
   logic                  pop;
   logic                  valid_int;
   logic                  accept;

   // Indices run 0,1,2,0,... over the three buffer slots.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

   // Reserve a slot for the word still in flight so a pop can never overrun
   // the buffer; this uses registered state only, keeping m_ready out of r_en.
   assign occupancy = {1'b0, level} + {2'b00, inflight};
   assign pop       = !rrst && !bus.empty && (occupancy < 3'd3);
   assign bus.r_en  = pop;

   assign valid_int   = (level != 2'd0);
   assign accept      = valid_int && bus.m_ready;
   assign bus.m_valid = valid_int;
   assign bus.m_data  = buf_mem[ri];
   assign bus.m_last  = valid_int && (beat_cnt == BEAT_LAST);

   always_ff @(posedge rclk) begin
      if (rrst) begin
         for (int k = 0; k < 3; k++) begin
            buf_mem[k] <= '0;
         end
         wi       <= 2'd0;
         ri       <= 2'd0;
         level    <= 2'd0;
         inflight <= 1'b0;
         beat_cnt <= '0;
         beats    <= '0;
      end else begin
         // fifo_data is only meaningful the cycle after a pop.
         inflight <= pop;
         if (inflight) begin
            buf_mem[wi] <= bus.fifo_data;
            wi          <= next_idx(wi);
         end
         if (accept) begin
            ri       <= next_idx(ri);
            beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
            beats    <= beats + 1'b1;
         end
         level <= level + {1'b0, inflight} - {1'b0, accept};
      end
   end

endmodule

// File: doc/fifo_read_streamer.md
# fifo_read_streamer

Read-side adapter on the `rclk` domain, directly downstream of the asynchronous FIFO's read port. It pops the FIFO whenever it has buffer room, absorbing the FIFO's one-cycle registered read latency. It presents the words as a valid/ready stream with a 3-entry skid buffer and a packet-boundary marker every `PKT_LEN` beats. Sustained throughput is one word per cycle, and there is no combinational path from `m_ready` to `r_en`.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: FIFO word width.
- `PKT_LEN`, default 16: beats per packet; legal range 1..65535.
- `CNT_WIDTH`, default 32: width of the accepted-beat counter.

Ports:
- `rclk`  input  1  read-domain clock; all state updates on its rising edge.
- `rrst`  input  1  reset, synchronous, active-high.
- `empty`  input  1  FIFO empty flag (`rclk` domain).
- `r_en`  output  1  FIFO pop request.
- `fifo_data`  input  DATA_WIDTH  FIFO read data; valid in the cycle after a cycle with `r_en`=1.
- `m_valid`  output  1  stream data valid.
- `m_data`  output  DATA_WIDTH  stream data.
- `m_last`  output  1  last beat of a `PKT_LEN`-beat packet.
- `m_ready`  input  1  downstream accepts the beat.
- `level`  output  2  buffered word count, 0..3.
- `beats`  output  CNT_WIDTH  total accepted beats; wraps modulo 2^CNT_WIDTH.

## Operation
- State:
  - 3-entry buffer `buf[0..2]`.
  - Write index `wi` and read index `ri`, each 2 bits, wrapping 2→0; the value 3 is never reached.
  - `level` (0..3).
  - `inflight` flag (0/1).
  - `beat_cnt`, 0..PKT_LEN-1, width max(1, clog2(PKT_LEN)).
  - `beats`.
- Pop issue: `r_en` = !rrst && !empty && (level + inflight < 3). It is driven from registers and `empty` only.
- `inflight` next value = `r_en`. At most one read is outstanding.
- Capture: when `inflight`=1, `fifo_data` is written to `buf[wi]` and `wi` advances.
- Output:
  - `m_valid` = (level != 0).
  - `m_data` = `buf[ri]`.
  - `m_last` = m_valid && (beat_cnt == PKT_LEN-1).
- Accept: when `m_valid` && `m_ready`, the beat is accepted.
  - `ri` advances.
  - `beat_cnt` increments, or wraps to 0 after PKT_LEN-1.
  - `beats` increments.
- Level update: `level` next = level + inflight − accept. Capture and accept in the same cycle leave `level` unchanged.
- Invariant: level + inflight ≤ 3 at all times, so the buffer never overflows and no word is ever dropped or duplicated.
- `PKT_LEN`=1: `m_last` = `m_valid` on every beat.
- Holding rule: while `m_valid`=1 and `m_ready`=0, `m_data` and `m_last` hold stable.
- `empty` handling: the block relies on the FIFO's pessimistic `empty`. A pop is never issued while `empty`=1.

## Timing
- Reset values (cycle after `rrst` sampled high):
  - `r_en`=0 (also forced 0 combinationally while `rrst`=1).
  - `m_valid`=0, `m_last`=0.
  - `m_data`=0; all buffer entries cleared.
  - `level`=0, `beats`=0, `inflight`=0, `beat_cnt`=0, `wi`=`ri`=0.
- Latency, with the buffer empty:
  - `empty` falls in cycle T.
  - `r_en`=1 in T.
  - `fifo_data` is valid in T+1 and is captured at the end of T+1.
  - `m_valid`=1 in T+2.
- Throughput: with `empty`=0 and `m_ready`=1, steady state is level=1, inflight=1, one pop and one accept per cycle.
- Backpressure: with `m_ready`=0, pops continue until level + inflight = 3. Then `r_en`=0 until the next accept.
  - In the cycle after an accept, `r_en` may reassert.
- Reset mid-operation: an outstanding read is discarded. `fifo_data` in the cycle after reset is not captured, and the FIFO is expected to be reset in the same window.
- Counter wrap: `beats` wraps from 2^CNT_WIDTH−1 to 0 without a flag.

## Test plan
- Reset, then preload 5 words 0x11..0x15, `m_ready`=1:
  - first `r_en` in the cycle `empty` falls;
  - `m_valid` rises 2 cycles later;
  - 0x11..0x15 appear on 5 consecutive cycles;
  - `beats`=5.
- Preload 8 words, `m_ready`=0 for 10 cycles:
  - exactly 3 pops issued;
  - `level`=3, `r_en`=0, `m_data`=first word held stable;
  - then `m_ready`=1: all 8 words emerge in order, none lost.
- `PKT_LEN`=4, stream 12 words with random `m_ready`:
  - `m_last`=1 exactly on beats 4, 8, 12;
  - `beat_cnt` back to 0 afterwards.
- Toggle `empty` every cycle with `m_ready`=1:
  - pop count equals the number of accepted beats;
  - no `r_en` while `empty`=1;
  - data order preserved.
- Assert `rrst` for 1 cycle while level=2 and inflight=1:
  - next cycle `m_valid`=0, `level`=0, `beats`=0;
  - the stale `fifo_data` (e.g. 0xAA) never appears on `m_data`.
- `CNT_WIDTH`=4: accept 17 beats → `beats`=1.
